fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the machine control block; consumes its pc_src_out and flush_out.
- Owns the fetch PC and issues req/ack reads to instruction memory.
- Presents one instruction at a time to decode with a valid/stall handshake.
- Detects misaligned fetch targets and returns them as misaligned_instr_in to machine control.

Parameters:
BOOT_ADDR, 32'h0000_0000, first fetch address after reset and target for pc_src BOOT
NOP_INSTR, 32'h0000_0013, value of instr_out while reset is asserted

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  synchronous, active-low reset
pc_src_in  input  2  redirect select: 00 BOOT, 01 NEXT, 10 TRAP, 11 EPC; sampled only when flush_in=1
flush_in  input  1  redirect request from machine control
trap_addr_in  input  32  trap vector (mtvec)
epc_in  input  32  return address (mepc)
branch_taken_in  input  1  branch/jump resolved taken
branch_target_in  input  32  branch/jump target
stall_in  input  1  decode not ready
imem_req_out  output  1  memory read request
imem_addr_out  output  32  memory read address
imem_ack_in  input  1  read data valid; single-cycle pulse
imem_rdata_in  input  32  read data
instr_valid_out  output  1  instr_out/pc_out valid
instr_out  output  32  fetched instruction
pc_out  output  32  address of instr_out
misaligned_instr_out  output  1  one-cycle pulse: fetch target not word-aligned
bad_addr_out  output  32  faulting target; held until next misaligned event

Behaviour:
- Reset (rst_in=0 at clock edge) from any state, including with a request outstanding:
  - state BOOT; imem_req_out=0; imem_addr_out=BOOT_ADDR.
  - instr_valid_out=0; instr_out=NOP_INSTR; pc_out=BOOT_ADDR.
  - misaligned_instr_out=0; bad_addr_out=0.
  - Memory must tolerate an abandoned request.
- Redirect target, priority order:
  - flush_in=1: BOOT→BOOT_ADDR, TRAP→trap_addr_in, EPC→epc_in, NEXT→pc_out+4.
  - Otherwise, if branch_taken_in=1: branch_target_in.
  - flush_in beats branch_taken_in in the same cycle.
- All outputs are registered; imem_addr_out comes from the fetch address register.
- State BOOT:
  - Next cycle goes to FETCH with address BOOT_ADDR.
  - flush/branch are ignored in BOOT.
- State FETCH:
  - imem_req_out=1; address held stable until ack.
  - ack and no redirect: instr_out<=imem_rdata_in, pc_out<=address, instr_valid_out<=1, address<=address+4 (mod 2^32); go to HOLD.
  - Redirect with ack in the same cycle: discard data; address<=target; stay in FETCH. Req stays 1, so the next cycle requests the target.
  - Redirect without ack: latch target in redirect register; go to KILL. Req stays 1 and the old address is held, because a request is never withdrawn.
- State KILL:
  - imem_req_out=1 with the old address.
  - Further redirects overwrite the redirect register; the latest wins.
  - On ack: discard data; address<=redirect register; go to FETCH.
- State HOLD:
  - imem_req_out=0; instr_valid_out=1.
  - Redirect: instr_valid_out<=0; address<=target; go to FETCH. A redirect overrides a same-cycle consume.
  - stall_in=0 (consumed): instr_valid_out<=0; go to FETCH.
  - stall_in=1: hold all outputs unchanged.
- Misaligned target (target[1:0]≠00) on any accepted redirect, instead of the transitions above:
  - Go to ERR; misaligned_instr_out=1 for exactly one cycle; bad_addr_out<=target; instr_valid_out<=0.
  - If entered from FETCH without ack: latch misaligned state and finish the outstanding request through KILL, then go to ERR instead of FETCH.
- State ERR:
  - imem_req_out=0; instr_valid_out=0.
  - Only a flush_in with an aligned target leaves ERR (to FETCH); branch_taken_in is ignored.
  - A misaligned flush target pulses misaligned_instr_out again and stays in ERR.
- Throughput: 1 instruction per 2 cycles with a zero-wait memory (ack in the same cycle as req).
- Latency: ack→instr_valid_out=1 on the next edge.

Test Plan:
- Reset release, BOOT_ADDR=0x100, ack every cycle req=1: imem_addr_out sequence 0x100, 0x104, 0x108; pc_out matches; instr_out equals rdata; valid toggles 1-of-2 cycles.
- HOLD with instr 0xDEADBEEF, stall_in=1 for 5 cycles: instr_out, pc_out and valid remain constant and imem_req_out=0; after stall release the next fetch address is pc_out+4.
- FETCH at 0x200, ack delayed 3 cycles, flush_in=1 with pc_src=TRAP and trap_addr=0x80 in cycle 1: addr stays 0x200 until ack; that data is never valid; the next request addr is 0x80.
- Same-cycle flush (EPC, epc=0x340) and branch_taken (target 0x500) in HOLD: next addr 0x340; valid drops.
- Branch to 0x502: misaligned_instr_out pulses for 1 cycle, bad_addr_out=0x502, no req; a later flush to TRAP 0x80 resumes fetch at 0x80.
- rst_in=0 for one cycle while in KILL: next cycle is BOOT with req=0 and instr_out=0x00000013; fetching restarts at BOOT_ADDR.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus plus decode valid/stall handshake
//   master (fetch side): drives imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out
//                        samples imem_ack_in, imem_rdata_in, stall_in
//   slave (memory/decode side): the mirror image
interface fetch_unit_if;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic        stall_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  modport master (
    output imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out,
    input  imem_ack_in, imem_rdata_in, stall_in
  );
  modport slave (
    input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out,
    output imem_ack_in, imem_rdata_in, stall_in
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC owner, req/ack imem reader, one-at-a-time decode feed, misalignment detect
//   clk_in, rst_in (sync, active-low); pc_src_in/flush_in/trap_addr_in/epc_in redirect from machine control;
//   branch_taken_in/branch_target_in from execute; bus = imem + decode handshake (master);
//   misaligned_instr_out one-cycle pulse with bad_addr_out holding the faulting target
module fetch_unit #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        pc_src_in,
  input  logic              flush_in,
  input  logic [31:0]       trap_addr_in,
  input  logic [31:0]       epc_in,
  input  logic              branch_taken_in,
  input  logic [31:0]       branch_target_in,
  fetch_unit_if.master      bus,
  output logic              misaligned_instr_out,
  output logic [31:0]       bad_addr_out
);
  typedef enum logic [2:0] {BOOT, FETCH, KILL, HOLD, ERR} state_t;
  state_t      state;
  logic [31:0] redir_q;
  logic        redir_mis_q;
  logic [31:0] flush_tgt, tgt, kill_tgt;
  logic        redir, mis, kill_mis;
  always_comb begin
    flush_tgt = pc_src_in == 2'b00 ? BOOT_ADDR :
                pc_src_in == 2'b01 ? bus.pc_out + 32'd4 :
                pc_src_in == 2'b10 ? trap_addr_in : epc_in;
    tgt       = flush_in ? flush_tgt : branch_target_in;
    redir     = flush_in | branch_taken_in;
    mis       = |tgt[1:0];
    // in KILL a same-cycle redirect supersedes the one already latched
    kill_tgt  = redir ? tgt : redir_q;
    kill_mis  = redir ? mis : redir_mis_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state                <= BOOT;
      bus.imem_req_out     <= 1'b0;
      bus.imem_addr_out    <= BOOT_ADDR;
      bus.instr_valid_out  <= 1'b0;
      bus.instr_out        <= NOP_INSTR;
      bus.pc_out           <= BOOT_ADDR;
      misaligned_instr_out <= 1'b0;
      bad_addr_out         <= 32'h0;
      redir_q              <= BOOT_ADDR;
      redir_mis_q          <= 1'b0;
    end else begin
      misaligned_instr_out <= 1'b0;
      case (state)
        BOOT: begin
          state             <= FETCH;
          bus.imem_req_out  <= 1'b1;
          bus.imem_addr_out <= BOOT_ADDR;
        end
        FETCH: begin
          if (redir && !bus.imem_ack_in) begin
            // the request cannot be withdrawn; park the target until the ack drains it
            state       <= KILL;
            redir_q     <= tgt;
            redir_mis_q <= mis;
          end else if (redir && mis) begin
            state                <= ERR;
            bus.imem_req_out     <= 1'b0;
            misaligned_instr_out <= 1'b1;
            bad_addr_out         <= tgt;
          end else if (redir) begin
            bus.imem_addr_out <= tgt;
          end else if (bus.imem_ack_in) begin
            state               <= HOLD;
            bus.imem_req_out    <= 1'b0;
            bus.instr_valid_out <= 1'b1;
            bus.instr_out       <= bus.imem_rdata_in;
            bus.pc_out          <= bus.imem_addr_out;
            bus.imem_addr_out   <= bus.imem_addr_out + 32'd4;
          end
        end
        KILL: begin
          if (redir) begin
            redir_q     <= tgt;
            redir_mis_q <= mis;
          end
          if (bus.imem_ack_in && kill_mis) begin
            state                <= ERR;
            bus.imem_req_out     <= 1'b0;
            misaligned_instr_out <= 1'b1;
            bad_addr_out         <= kill_tgt;
          end else if (bus.imem_ack_in) begin
            state             <= FETCH;
            bus.imem_addr_out <= kill_tgt;
          end
        end
        HOLD: begin
          if (redir) begin
            bus.instr_valid_out <= 1'b0;
            if (mis) begin
              state                <= ERR;
              misaligned_instr_out <= 1'b1;
              bad_addr_out         <= tgt;
            end else begin
              state             <= FETCH;
              bus.imem_req_out  <= 1'b1;
              bus.imem_addr_out <= tgt;
            end
          end else if (!bus.stall_in) begin
            state               <= FETCH;
            bus.instr_valid_out <= 1'b0;
            bus.imem_req_out    <= 1'b1;
          end
        end
        ERR: begin
          if (flush_in && mis) begin
            misaligned_instr_out <= 1'b1;
            bad_addr_out         <= tgt;
          end else if (flush_in) begin
            state             <= FETCH;
            bus.imem_req_out  <= 1'b1;
            bus.imem_addr_out <= tgt;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tasks for fetch_unit with hand-computed expectations
module tb_fetch_unit;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [1:0]  pc_src_in = 2'b00;
  logic        flush_in = 1'b0;
  logic [31:0] trap_addr_in = 32'h0;
  logic [31:0] epc_in = 32'h0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_target_in = 32'h0;
  logic        misaligned_instr_out;
  logic [31:0] bad_addr_out;
  int          total = 0;
  int          bad = 0;
  fetch_unit_if bus();
  fetch_unit #(.BOOT_ADDR(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pc_src_in(pc_src_in), .flush_in(flush_in),
    .trap_addr_in(trap_addr_in), .epc_in(epc_in), .branch_taken_in(branch_taken_in),
    .branch_target_in(branch_target_in), .bus(bus),
    .misaligned_instr_out(misaligned_instr_out), .bad_addr_out(bad_addr_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic test_reset;
    rst_in = 1'b0;
    tick();
    tick();
    total++; if (bus.imem_req_out !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.imem_req_out); end
    total++; if (bus.imem_addr_out !== 32'h100) begin bad++; $display("FAIL reset_addr got=%h exp=00000100", bus.imem_addr_out); end
    total++; if (bus.instr_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid_out); end
    total++; if (bus.instr_out !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", bus.instr_out); end
    total++; if (bus.pc_out !== 32'h100) begin bad++; $display("FAIL reset_pc got=%h exp=00000100", bus.pc_out); end
    total++; if (misaligned_instr_out !== 1'b0 || bad_addr_out !== 32'h0) begin bad++; $display("FAIL reset_mis got=%b/%h exp=0/00000000", misaligned_instr_out, bad_addr_out); end
  endtask
  task automatic test_stream;
    logic [31:0] data [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    rst_in = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.imem_req_out !== 1'b1 || bus.instr_valid_out !== 1'b0) begin bad++; $display("FAIL stream_fetch%0d got=req%b/val%b exp=req1/val0", i, bus.imem_req_out, bus.instr_valid_out); end
      total++; if (bus.imem_addr_out !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL stream_addr%0d got=%h exp=%h", i, bus.imem_addr_out, 32'h100 + 32'(4 * i)); end
      bus.imem_ack_in = 1'b1;
      bus.imem_rdata_in = data[i];
      tick();
      bus.imem_ack_in = 1'b0;
      total++; if (bus.instr_valid_out !== 1'b1 || bus.imem_req_out !== 1'b0) begin bad++; $display("FAIL stream_hold%0d got=val%b/req%b exp=val1/req0", i, bus.instr_valid_out, bus.imem_req_out); end
      total++; if (bus.instr_out !== data[i] || bus.pc_out !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL stream_data%0d got=%h@%h exp=%h@%h", i, bus.instr_out, bus.pc_out, data[i], 32'h100 + 32'(4 * i)); end
      tick();
    end
  endtask
  task automatic test_stall;
    bus.imem_ack_in = 1'b1;
    bus.imem_rdata_in = 32'hDEAD_BEEF;
    bus.stall_in = 1'b1;
    tick();
    bus.imem_ack_in = 1'b0;
    bus.imem_rdata_in = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.instr_valid_out !== 1'b1 || bus.instr_out !== 32'hDEAD_BEEF || bus.pc_out !== 32'h10C || bus.imem_req_out !== 1'b0) begin bad++; $display("FAIL stall%0d got=val%b %h@%h req%b exp=val1 deadbeef@0000010c req0", i, bus.instr_valid_out, bus.instr_out, bus.pc_out, bus.imem_req_out); end
    end
    bus.stall_in = 1'b0;
    tick();
    total++; if (bus.imem_addr_out !== 32'h110 || bus.imem_req_out !== 1'b1 || bus.instr_valid_out !== 1'b0) begin bad++; $display("FAIL stall_release got=%h req%b val%b exp=00000110 req1 val0", bus.imem_addr_out, bus.imem_req_out, bus.instr_valid_out); end
  endtask
  task automatic test_kill_trap;
    branch_taken_in = 1'b1;
    branch_target_in = 32'h200;
    bus.imem_ack_in = 1'b1;
    bus.imem_rdata_in = 32'hAAAA_AAAA;
    tick();
    branch_taken_in = 1'b0;
    bus.imem_ack_in = 1'b0;
    total++; if (bus.imem_addr_out !== 32'h200 || bus.imem_req_out !== 1'b1 || bus.instr_valid_out !== 1'b0) begin bad++; $display("FAIL redirect_ack got=%h req%b val%b exp=00000200 req1 val0", bus.imem_addr_out, bus.imem_req_out, bus.instr_valid_out); end
    flush_in = 1'b1;
    pc_src_in = 2'b10;
    trap_addr_in = 32'h80;
    tick();
    flush_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.imem_addr_out !== 32'h200 || bus.imem_req_out !== 1'b1 || bus.instr_valid_out !== 1'b0) begin bad++; $display("FAIL kill_hold%0d got=%h req%b val%b exp=00000200 req1 val0", i, bus.imem_addr_out, bus.imem_req_out, bus.instr_valid_out); end
      tick();
    end
    bus.imem_ack_in = 1'b1;
    bus.imem_rdata_in = 32'hBAD0_BAD0;
    tick();
    bus.imem_ack_in = 1'b0;
    total++; if (bus.imem_addr_out !== 32'h80 || bus.imem_req_out !== 1'b1 || bus.instr_valid_out !== 1'b0) begin bad++; $display("FAIL kill_drain got=%h req%b val%b exp=00000080 req1 val0", bus.imem_addr_out, bus.imem_req_out, bus.instr_valid_out); end
    bus.imem_ack_in = 1'b1;
    bus.imem_rdata_in = 32'h0000_0093;
    tick();
    bus.imem_ack_in = 1'b0;
    total++; if (bus.instr_out !== 32'h93 || bus.pc_out !== 32'h80 || bus.instr_valid_out !== 1'b1) begin bad++; $display("FAIL trap_fetch got=%h@%h val%b exp=00000093@00000080 val1", bus.instr_out, bus.pc_out, bus.instr_valid_out); end
  endtask
  task automatic test_flush_vs_branch;
    flush_in = 1'b1;
    pc_src_in = 2'b11;
    epc_in = 32'h340;
    branch_taken_in = 1'b1;
    branch_target_in = 32'h500;
    bus.stall_in = 1'b1;
    tick();
    flush_in = 1'b0;
    branch_taken_in = 1'b0;
    bus.stall_in = 1'b0;
    total++; if (bus.imem_addr_out !== 32'h340 || bus.imem_req_out !== 1'b1 || bus.instr_valid_out !== 1'b0) begin bad++; $display("FAIL flush_prio got=%h req%b val%b exp=00000340 req1 val0", bus.imem_addr_out, bus.imem_req_out, bus.instr_valid_out); end
    bus.imem_ack_in = 1'b1;
    bus.imem_rdata_in = 32'h1357_9BDF;
    tick();
    bus.imem_ack_in = 1'b0;
    total++; if (bus.instr_out !== 32'h1357_9BDF || bus.pc_out !== 32'h340) begin bad++; $display("FAIL epc_fetch got=%h@%h exp=13579bdf@00000340", bus.instr_out, bus.pc_out); end
  endtask
  task automatic test_misaligned;
    branch_taken_in = 1'b1;
    branch_target_in = 32'h502;
    tick();
    total++; if (misaligned_instr_out !== 1'b1 || bad_addr_out !== 32'h502 || bus.imem_req_out !== 1'b0 || bus.instr_valid_out !== 1'b0) begin bad++; $display("FAIL mis_branch got=mis%b %h req%b val%b exp=mis1 00000502 req0 val0", misaligned_instr_out, bad_addr_out, bus.imem_req_out, bus.instr_valid_out); end
    branch_target_in = 32'h600;
    tick();
    total++; if (misaligned_instr_out !== 1'b0 || bad_addr_out !== 32'h502 || bus.imem_req_out !== 1'b0) begin bad++; $display("FAIL mis_pulse got=mis%b %h req%b exp=mis0 00000502 req0", misaligned_instr_out, bad_addr_out, bus.imem_req_out); end
    branch_taken_in = 1'b0;
    flush_in = 1'b1;
    pc_src_in = 2'b10;
    trap_addr_in = 32'h81;
    tick();
    total++; if (misaligned_instr_out !== 1'b1 || bad_addr_out !== 32'h81 || bus.imem_req_out !== 1'b0) begin bad++; $display("FAIL mis_flush got=mis%b %h req%b exp=mis1 00000081 req0", misaligned_instr_out, bad_addr_out, bus.imem_req_out); end
    trap_addr_in = 32'h80;
    tick();
    flush_in = 1'b0;
    total++; if (bus.imem_addr_out !== 32'h80 || bus.imem_req_out !== 1'b1 || misaligned_instr_out !== 1'b0 || bad_addr_out !== 32'h81) begin bad++; $display("FAIL err_exit got=%h req%b mis%b %h exp=00000080 req1 mis0 00000081", bus.imem_addr_out, bus.imem_req_out, misaligned_instr_out, bad_addr_out); end
    flush_in = 1'b1;
    trap_addr_in = 32'h86;
    tick();
    flush_in = 1'b0;
    total++; if (misaligned_instr_out !== 1'b0 || bus.imem_addr_out !== 32'h80 || bus.imem_req_out !== 1'b1) begin bad++; $display("FAIL mis_kill got=mis%b %h req%b exp=mis0 00000080 req1", misaligned_instr_out, bus.imem_addr_out, bus.imem_req_out); end
    bus.imem_ack_in = 1'b1;
    tick();
    bus.imem_ack_in = 1'b0;
    total++; if (misaligned_instr_out !== 1'b1 || bad_addr_out !== 32'h86 || bus.imem_req_out !== 1'b0) begin bad++; $display("FAIL mis_kill_err got=mis%b %h req%b exp=mis1 00000086 req0", misaligned_instr_out, bad_addr_out, bus.imem_req_out); end
    flush_in = 1'b1;
    trap_addr_in = 32'h80;
    tick();
    flush_in = 1'b0;
    total++; if (bus.imem_addr_out !== 32'h80 || bus.imem_req_out !== 1'b1) begin bad++; $display("FAIL mis_kill_exit got=%h req%b exp=00000080 req1", bus.imem_addr_out, bus.imem_req_out); end
  endtask
  task automatic test_reset_in_kill;
    branch_taken_in = 1'b1;
    branch_target_in = 32'h700;
    tick();
    branch_taken_in = 1'b0;
    total++; if (bus.imem_addr_out !== 32'h80 || bus.imem_req_out !== 1'b1) begin bad++; $display("FAIL kill_enter got=%h req%b exp=00000080 req1", bus.imem_addr_out, bus.imem_req_out); end
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    total++; if (bus.imem_req_out !== 1'b0 || bus.instr_out !== 32'h13 || bus.imem_addr_out !== 32'h100 || bus.instr_valid_out !== 1'b0) begin bad++; $display("FAIL kill_reset got=req%b %h %h val%b exp=req0 00000013 00000100 val0", bus.imem_req_out, bus.instr_out, bus.imem_addr_out, bus.instr_valid_out); end
    tick();
    total++; if (bus.imem_req_out !== 1'b1 || bus.imem_addr_out !== 32'h100) begin bad++; $display("FAIL reboot got=req%b %h exp=req1 00000100", bus.imem_req_out, bus.imem_addr_out); end
  endtask
  initial begin
    bus.imem_ack_in = 1'b0;
    bus.imem_rdata_in = 32'h0;
    bus.stall_in = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_kill_trap();
    test_flush_vs_branch();
    test_misaligned();
    test_reset_in_kill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
